// File: rtl/ising_config.sv
// rtl/ising_config.sv - shared configuration constants and types for the ising GPIO config space
package ising_config;

  // GPIO configuration bus geometry
  localparam int gpio_addr_width = 16;
  localparam int gpio_data_width = 8;

  // ADC capture geometry
  localparam int adc_buffer_len = 256;
  localparam int adc_sample_w   = 16;

  // Register map (adc_run_reg is 17 bits wide; only the low 16 bits are decoded)
  localparam logic [16:0] adc_run_reg      = 17'h0_0005;
  localparam logic [15:0] mac_adc_read_reg = 16'h000A;

  // Run-register control bits
  localparam int adc_run_arm_bit   = 0;
  localparam int adc_run_abort_bit = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } adc_cap_state_t;

endpackage

// File: rtl/adc_capture_buf.sv
// rtl/adc_capture_buf.sv - simple dual-port sample RAM with registered read
module adc_capture_buf
  import ising_config::*;
#(
  parameter int DEPTH = adc_buffer_len,
  parameter int WIDTH = adc_sample_w
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus one-cycle registered read; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - armed/triggered ADC sample capture with byte-wise readback
module adc_capture_ctrl
  import ising_config::*;
#(
  parameter int SAMPLE_W = adc_sample_w,
  parameter int BUF_LEN  = adc_buffer_len,
  parameter int ADDR_W   = gpio_addr_width,
  parameter int DATA_W   = gpio_data_width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic                trig,
  input  logic [SAMPLE_W-1:0] adc_tdata,
  input  logic                adc_tvalid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done
);

  localparam int BYTES  = SAMPLE_W / DATA_W;
  localparam int WP_W   = $clog2(BUF_LEN);
  localparam int RP_W   = $clog2(BUF_LEN * BYTES);
  localparam int BSH    = $clog2(BYTES);
  localparam int BSEL_W = (BSH > 0) ? BSH : 1;

  adc_cap_state_t state_q, state_d;

  logic [WP_W-1:0]     wr_ptr_q;
  logic [RP_W-1:0]     rd_ptr_q;
  logic                clr_ptrs;

  logic [15:0]         addr_lo;
  logic                run_wr;
  logic                rd_wr;
  logic                abort_req;
  logic                arm_req;
  logic                sample_we;
  logic                rd_hit;

  logic [WP_W-1:0]     rd_word_addr;
  logic [BSEL_W-1:0]   rd_byte_sel;
  logic [SAMPLE_W-1:0] buf_rdata;

  logic                rd_pend_q;
  logic                rd_hit_q;
  logic [BSEL_W-1:0]   rd_byte_q;
  logic [DATA_W-1:0]   rd_byte_val;

  // Only the arm and abort bits of the run register carry meaning
  logic unused_w_data;
  assign unused_w_data = ^w_data[DATA_W-1:2];

  // Register decode on the low 16 address bits
  assign addr_lo   = 16'(w_addr);
  assign run_wr    = w_en && (addr_lo == adc_run_reg[15:0]);
  assign rd_wr     = w_en && (addr_lo == mac_adc_read_reg);
  assign abort_req = run_wr && w_data[adc_run_abort_bit];
  assign arm_req   = run_wr && w_data[adc_run_arm_bit];

  // Buffer write only in CAPTURE, buffer read only in DONE, so the ports never collide
  assign sample_we = (state_q == CAPTURE) && adc_tvalid;
  assign rd_hit    = rd_wr && (state_q == DONE);

  // Low rd_ptr bits pick the byte within a sample, the rest pick the sample
  assign rd_word_addr = WP_W'(rd_ptr_q >> BSH);
  assign rd_byte_sel  = (BSH > 0) ? BSEL_W'(rd_ptr_q) : '0;

  adc_capture_buf #(
    .DEPTH (BUF_LEN),
    .WIDTH (SAMPLE_W)
  ) u_buf (
    .clk   (clk),
    .we    (sample_we),
    .waddr (wr_ptr_q),
    .wdata (adc_tdata),
    .re    (rd_hit),
    .raddr (rd_word_addr),
    .rdata (buf_rdata)
  );

  // Capture state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pointer clear and status outputs; abort outranks everything
  always_comb begin
    state_d  = state_q;
    clr_ptrs = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    if (abort_req) begin
      state_d  = IDLE;
      clr_ptrs = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_req) begin
            state_d  = ARMED;
            clr_ptrs = 1'b1;
          end
        end
        ARMED: begin
          if (trig) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (adc_tvalid && (wr_ptr_q == WP_W'(BUF_LEN - 1))) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (arm_req) begin
            state_d  = ARMED;
            clr_ptrs = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy = (state_q == ARMED) || (state_q == CAPTURE);
    done = (state_q == DONE);
  end

  // Write and read pointers; rd_ptr wraps naturally after the last byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_ptrs) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (sample_we) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_hit) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Track each read request alongside the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_byte_q <= '0;
    end else begin
      rd_pend_q <= rd_wr;
      rd_hit_q  <= rd_hit;
      rd_byte_q <= rd_byte_sel;
    end
  end

  assign rd_byte_val = DATA_W'(buf_rdata >> (int'(rd_byte_q) * DATA_W));

  // Output register: a miss (not in DONE) answers 0x00; data holds between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data <= rd_hit_q ? rd_byte_val : '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;
  import ising_config::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_en = 1'b0;
  logic [15:0] w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        trig = 1'b0;
  logic [15:0] adc_tdata = '0;
  logic        adc_tvalid = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the samples the bench expects to sit in the buffer
  logic [15:0] exp_buf [256];
  int          n_stored;

  adc_capture_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .trig       (trig),
    .adc_tdata  (adc_tdata),
    .adc_tvalid (adc_tvalid),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    cyc();
    w_en = 1'b0;
  endtask

  // Expected readback byte k of a completed capture (low byte first, wraps every 512)
  function automatic logic [7:0] exp_byte(input int k);
    logic [15:0] s;
    s = exp_buf[(k % 512) / 2];
    return ((k % 2) == 1) ? s[15:8] : s[7:0];
  endfunction

  // Arm, trigger, feed samples until the model holds 256; returns cycles spent in CAPTURE
  task automatic do_capture(input int mode, input int pre_trig, input int arm_at, output int cycles);
    int early;
    early = 0;
    wr(16'h0005, 8'h01);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy: got %b want 1", busy); end
    repeat (pre_trig) cyc();
    trig = 1'b1; adc_tvalid = 1'b1; adc_tdata = 16'hDEAD;
    cyc();
    trig = 1'b0;
    n_stored = 0;
    cycles = 0;
    while (n_stored < 256 && cycles < 4000) begin
      logic        v;
      logic [15:0] d;
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cycles % 2) == 1);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (mode == 2) ? 16'($urandom) : 16'h0100 + 16'(n_stored);
      adc_tvalid = v; adc_tdata = d;
      if (cycles == arm_at) begin w_en = 1'b1; w_addr = 16'h0005; w_data = 8'h01; end
      cyc();
      w_en = 1'b0;
      if (v) begin exp_buf[n_stored] = d; n_stored++; end
      cycles++;
      if (n_stored < 256 && (done !== 1'b0 || busy !== 1'b1)) early++;
    end
    adc_tvalid = 1'b0;
    n_cmp++;
    if (early != 0) begin n_err++; $display("FAIL capture_status: got %0d bad cycles want 0", early); end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL capture_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
  endtask

  // Back-to-back reads every cycle; collect every rd_valid pulse and compare to the model
  task automatic read_all(input int n_bytes, input bit expect_zero);
    logic [7:0] q[$];
    logic [7:0] want;
    for (int i = 0; i < n_bytes + 2; i++) begin
      if (i < n_bytes) begin w_en = 1'b1; w_addr = 16'h000A; w_data = 8'($urandom); end
      else w_en = 1'b0;
      cyc();
      if (rd_valid === 1'b1) q.push_back(rd_data);
    end
    w_en = 1'b0;
    n_cmp++;
    if (q.size() != n_bytes) begin
      n_err++; $display("FAIL read_count: got %0d want %0d", q.size(), n_bytes);
    end
    for (int k = 0; k < q.size(); k++) begin
      want = expect_zero ? 8'h00 : exp_byte(k);
      n_cmp++;
      if (q[k] !== want) begin
        n_err++; $display("FAIL read_byte[%0d]: got %02h want %02h", k, q[k], want);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got busy=%b done=%b rd_valid=%b rd_data=%02h want all 0", busy, done, rd_valid, rd_data);
    end
    rst = 1'b1;
    cyc();
    wr(16'h000A, 8'h5A);
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_err++; $display("FAIL idle_read_t1: got rd_valid=%b want 0", rd_valid); end
    cyc();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      n_err++; $display("FAIL idle_read_t2: got rd_valid=%b rd_data=%02h want 1/00", rd_valid, rd_data);
    end
    cyc();
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_err++; $display("FAIL idle_read_pulse: got rd_valid=%b want 0", rd_valid); end
  endtask

  task automatic test_ramp_continuous();
    int c;
    do_capture(0, 50, -1, c);
    n_cmp++;
    if (c != 256) begin n_err++; $display("FAIL ramp_cycles: got %0d want 256", c); end
    read_all(513, 1'b0);
    repeat (3) cyc();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== exp_byte(512)) begin
      n_err++; $display("FAIL read_hold: got rd_valid=%b rd_data=%02h want 0/%02h", rd_valid, rd_data, exp_byte(512));
    end
  endtask

  task automatic test_ramp_toggle();
    int c;
    do_capture(1, 3, -1, c);
    n_cmp++;
    if (c != 512) begin n_err++; $display("FAIL toggle_cycles: got %0d want 512", c); end
    read_all(512, 1'b0);
  endtask

  task automatic test_abort();
    int c;
    wr(16'h0005, 8'h01);
    trig = 1'b1; cyc(); trig = 1'b0;
    adc_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin adc_tdata = 16'($urandom); cyc(); end
    adc_tvalid = 1'b0;
    wr(16'h0005, 8'h02);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_status: got busy=%b done=%b want 0/0", busy, done);
    end
    read_all(4, 1'b1);
    do_capture(2, 5, -1, c);
    read_all(512, 1'b0);
  endtask

  task automatic test_arm_ignored();
    int c;
    do_capture(0, 2, 50, c);
    n_cmp++;
    if (c != 256) begin n_err++; $display("FAIL arm_in_capture_cycles: got %0d want 256", c); end
    read_all(512, 1'b0);
  endtask

  task automatic test_trig_with_arm();
    int c;
    w_en = 1'b1; w_addr = 16'h0005; w_data = 8'h01; trig = 1'b1;
    cyc();
    w_en = 1'b0; trig = 1'b0;
    adc_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin adc_tdata = 16'($urandom); cyc(); end
    adc_tvalid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL trig_in_arm_cycle: got busy=%b done=%b want 1/0", busy, done);
    end
    do_capture(0, 1, -1, c);
    n_cmp++;
    if (c != 256) begin n_err++; $display("FAIL trig_after_arm_cycles: got %0d want 256", c); end
    read_all(16, 1'b0);
  endtask

  task automatic test_reset_mid_capture();
    wr(16'h0005, 8'h01);
    trig = 1'b1; cyc(); trig = 1'b0;
    adc_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin adc_tdata = 16'($urandom); cyc(); end
    rst = 1'b0;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_err++; $display("FAIL async_reset: got busy=%b done=%b rd_valid=%b rd_data=%02h want all 0", busy, done, rd_valid, rd_data);
    end
    cyc();
    adc_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) cyc();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_status: got done=%b busy=%b want 0/0", done, busy);
    end
    read_all(4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_ramp_continuous();
    test_ramp_toggle();
    test_abort();
    test_arm_ignored();
    test_trig_with_arm();
    test_reset_mid_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
